reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the processor datapath: 2^A entries of W bits each (default 8 x 8 bits).
- Two independent combinational read ports (A, B) feed the ALU operands.
- One synchronous write port takes the writeback value.
- Storage array is named core[0:2^A-1]; benches access it hierarchically for preload and checking.

Parameters:
- W, 8, data width of each register
- A, 3, address width; depth = 2^A

Ports:
- Clk  input  1  system clock; all writes on rising edge
- Rst_n  input  1  asynchronous active-low reset; clears all registers
- Wen  input  1  write enable, sampled on Clk rising edge
- Ra  input  A  read address, port A
- Rb  input  A  read address, port B
- Wd  input  A  write destination address
- Wdat  input  W  write data
- RdatA  output  W  read data, port A
- RdatB  output  W  read data, port B

Behaviour:
- Storage: core[0..2^A-1], each W bits; no hard-wired entries; register 0 is writable like any other.
- Reset:
  - Rst_n low asynchronously forces every core[i] to 0 regardless of Clk.
  - RdatA/RdatB therefore read 0 during reset.
  - Reset has priority over a coincident write.
- Write:
  - On posedge Clk with Rst_n high and Wen=1: core[Wd] <= Wdat.
  - Wen=0: no entry changes.
  - X/Z on Wen treated as no-write (implementation uses Wen==1 compare).
- Read:
  - RdatA = core[Ra], RdatB = core[Rb]; purely combinational, zero-cycle latency.
  - Outputs update within the same delta as address or storage changes.
- Ra==Rb: both ports return the same value.
- Read/write same address, same cycle (base build):
  - Read returns the old value until the clock edge, then the new value.
  - No internal forwarding.
- All address values 0..2^A-1 valid; no out-of-range case exists.
- Storage must be a plain unpacked array so hierarchical assignment (tb.inst.core[i] = v) preloads entries when Rst_n is high.
- No other state; no handshake; single write per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding):
  - When Wen=1 and Ra==Wd, RdatA = Wdat combinationally in the same cycle.
  - Likewise RdatB when Rb==Wd.
  - Storage update timing is unchanged.
  - Reset still forces reads to 0.
- Undefined: reads always reflect core[] contents only (base behaviour above).

Test Plan:
- Reset: Rst_n=0 for 10ns after preloading core[2]=96 -> core[0..7]==0, RdatA==0 with Ra=2; release Rst_n, Wen=0 -> contents stay 0.
- Combinational read: Rst_n=1; preload core = {1,31,96,0,0,0,0,5}; Wen=0, Ra=2, Rb=5, wait 10ns -> RdatA==96, RdatB==0; change Ra=7 -> RdatA==5 with no clock edge.
- Write: Wen=1, Wd=6, Wdat=10, one rising edge -> core[6]==10, other entries unchanged.
- Readback: Wen=0, Ra=6 -> RdatA==10 after 10ns.
- Write disable and same-address hazard:
  - Wen=0, Wd=1, Wdat=200 over two edges -> core[1] stays 31.
  - Wen=1, Wd=Ra=3, Wdat=55 -> before edge RdatA==0 (55 if REGFILE_BYPASS_EN), after edge RdatA==55.
- Async reset mid-operation: Wen=1, Wd=4, Wdat=9; assert Rst_n low between edges -> all entries 0 immediately; next edge while Rst_n low -> core[4] stays 0.

Source files
------------

// File: rtl/reg_file.sv
// General-purpose register file: 2^A x W storage, two combinational read ports, one synchronous write port.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 3
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Wen,
    input  logic [A-1:0] Ra,
    input  logic [A-1:0] Rb,
    input  logic [A-1:0] Wd,
    input  logic [W-1:0] Wdat,
    output logic [W-1:0] RdatA,
    output logic [W-1:0] RdatB
);

    localparam int unsigned DEPTH = 1 << A;

    // Plain unpacked array so that benches can preload and inspect entries hierarchically.
    logic [W-1:0] core [0:DEPTH-1];

    // Reset clears every entry and takes priority over a coincident write.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                core[i] <= '0;
            end
        end else if (Wen == 1'b1) begin
            core[Wd] <= Wdat;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write to a matching read port; reset still reads as zero.
    always_comb begin
        RdatA = core[Ra];
        RdatB = core[Rb];
        if (Rst_n && (Wen == 1'b1)) begin
            if (Ra == Wd) RdatA = Wdat;
            if (Rb == Wd) RdatB = Wdat;
        end
    end
`else
    always_comb begin
        RdatA = core[Ra];
        RdatB = core[Rb];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by randomized traffic against an array model.
module tb_reg_file;

    localparam int unsigned W = 8;
    localparam int unsigned A = 3;
    localparam int unsigned DEPTH = 1 << A;

    logic         Clk;
    logic         Rst_n;
    logic         Wen;
    logic [A-1:0] Ra;
    logic [A-1:0] Rb;
    logic [A-1:0] Wd;
    logic [W-1:0] Wdat;
    logic [W-1:0] RdatA;
    logic [W-1:0] RdatB;

    int total = 0;
    int bad   = 0;
    int model [0:DEPTH-1];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file #(.W(W), .A(A)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Wen  (Wen),
        .Ra   (Ra),
        .Rb   (Rb),
        .Wd   (Wd),
        .Wdat (Wdat),
        .RdatA(RdatA),
        .RdatB(RdatB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Value a read port should show right now, given the model and the pending write.
    function automatic int expect_rd(input int addr);
        if (!Rst_n) return 0;
        if (BYPASS && Wen == 1'b1 && addr == int'(Wd)) return int'(Wdat);
        return model[addr];
    endfunction

    task automatic check_core(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check($sformatf("%s[%0d]", tag, i), int'(dut.core[i]), model[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 0;
    endtask

    // One clock with the current inputs; the model commits the write the DUT should perform.
    task automatic step();
        @(posedge Clk);
        if (Rst_n && Wen == 1'b1) model[int'(Wd)] = int'(Wdat);
        #1;
    endtask

    initial begin
        int pre [0:7];
        pre = '{1, 31, 96, 0, 0, 0, 0, 5};

        Rst_n = 1'b1; Wen = 1'b0; Ra = '0; Rb = '0; Wd = '0; Wdat = '0;
        clear_model();

        // Reset wipes a preloaded entry asynchronously
        #2;
        dut.core[2] <= 8'd96;
        #1;
        Ra = 3'd2;
        Rst_n = 1'b0;
        #10;
        clear_model();
        check_core("rst_core");
        check("rst_rdatA", int'(RdatA), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step(); step();
        check_core("post_rst_core");

        // Combinational reads of a preloaded array
        @(negedge Clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            dut.core[i] <= W'(pre[i]);
            model[i] = pre[i];
        end
        #1;
        Ra = 3'd2; Rb = 3'd5;
        #10;
        check("rd_a_2", int'(RdatA), 96);
        check("rd_b_5", int'(RdatB), 0);
        Ra = 3'd7;
        #1;
        check("rd_a_7", int'(RdatA), 5);

        // Single write, other entries untouched
        @(negedge Clk);
        Wen = 1'b1; Wd = 3'd6; Wdat = 8'd10;
        step();
        Wen = 1'b0;
        check("wr_core6", int'(dut.core[6]), 10);
        check_core("wr_core");
        Ra = 3'd6;
        #10;
        check("readback6", int'(RdatA), 10);

        // Write disabled over two edges
        @(negedge Clk);
        Wen = 1'b0; Wd = 3'd1; Wdat = 8'd200;
        step(); step();
        check("wen0_core1", int'(dut.core[1]), 31);

        // Same-address read during write
        @(negedge Clk);
        Wen = 1'b1; Wd = 3'd3; Ra = 3'd3; Wdat = 8'd55;
        #1;
        check("hazard_before", int'(RdatA), BYPASS ? 55 : 0);
        step();
        check("hazard_after", int'(RdatA), 55);

        // Async reset between edges, held across an edge with a write pending
        @(negedge Clk);
        Wen = 1'b1; Wd = 3'd4; Wdat = 8'd9;
        #2;
        Rst_n = 1'b0;
        #1;
        clear_model();
        check_core("mid_rst_core");
        step();
        check("rst_blocks_wr", int'(dut.core[4]), 0);
        check("rst_rdatA", int'(RdatA), 0);
        @(negedge Clk);
        Wen = 1'b0;
        Rst_n = 1'b1;

        // Randomized traffic with occasional async reset pulses
        for (int n = 0; n < 400; n++) begin
            @(negedge Clk);
            Wen  = 1'($urandom_range(0, 1));
            Ra   = A'($urandom);
            Rb   = A'($urandom);
            Wd   = ($urandom_range(0, 3) == 0) ? Ra : A'($urandom);
            Wdat = W'($urandom);
            #1;
            check("rnd_rdA", int'(RdatA), expect_rd(int'(Ra)));
            check("rnd_rdB", int'(RdatB), expect_rd(int'(Rb)));
            if ($urandom_range(0, 39) == 0) begin
                Rst_n = 1'b0;
                #1;
                clear_model();
                check("rnd_rst_rdA", int'(RdatA), 0);
                check("rnd_rst_rdB", int'(RdatB), 0);
                Rst_n = 1'b1;
            end
            step();
            check("rnd_core", int'(dut.core[int'(Wd)]), model[int'(Wd)]);
        end
        check_core("final_core");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
